// File: rtl/rega_controller.sv
// rega_controller: irrigation valve sequencer (IDLE/WATER/COOL/FAULT) with J/K valve pulses.
module rega_controller #(
  parameter int MAX_ON = 30,
  parameter int COOL_T = 10
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       tick,
  input  logic       soil_dry,
  input  logic       tank_low,
  input  logic       manual_req,
  output logic       valve_j,
  output logic       valve_k,
  output logic       valve_on,
  output logic [1:0] state,
  output logic       alarm
);
  typedef enum logic [1:0] {IDLE = 2'b00, WATER = 2'b01, COOL = 2'b10, FAULT = 2'b11} st_t;
  st_t        st_q, st_d;
  logic [1:0] dry_q, low_q, man_q;
  logic       man_prev_q, man_rise_q, manual_q, manual_d, j_q, k_q;
  logic [7:0] cnt_q, cnt_d;
  logic       dry_s, low_s, expired;
  assign dry_s   = dry_q[1];
  assign low_s   = low_q[1];
  assign expired = tick && cnt_q == (st_q == WATER ? 8'(MAX_ON - 1) : 8'(COOL_T - 1));
  always_comb begin
    st_d     = st_q;
    manual_d = manual_q;
    case (st_q)
      IDLE:  if (low_s) st_d = FAULT;
             else if (dry_s || man_rise_q) begin
               st_d     = WATER;
               manual_d = man_rise_q;
             end
      WATER: st_d = low_s ? FAULT : (expired || (!manual_q && !dry_s)) ? COOL : WATER;
      COOL:  st_d = low_s ? FAULT : expired ? IDLE : COOL;
      FAULT: st_d = low_s ? FAULT : COOL;
    endcase
    cnt_d = (st_d != st_q) ? 8'd0 : (tick && (st_q == WATER || st_q == COOL)) ? cnt_q + 8'd1 : cnt_q;
  end
  // The rise detector is registered, giving manual requests one more cycle of latency than soil/tank.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      st_q       <= IDLE;
      dry_q      <= '0;
      low_q      <= '0;
      man_q      <= '0;
      man_prev_q <= 1'b0;
      man_rise_q <= 1'b0;
      manual_q   <= 1'b0;
      cnt_q      <= '0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
    end else begin
      st_q       <= st_d;
      dry_q      <= {dry_q[0], soil_dry};
      low_q      <= {low_q[0], tank_low};
      man_q      <= {man_q[0], manual_req};
      man_prev_q <= man_q[1];
      man_rise_q <= man_q[1] & ~man_prev_q;
      manual_q   <= manual_d;
      cnt_q      <= cnt_d;
      j_q        <= st_d == WATER && st_q != WATER;
      k_q        <= st_q == WATER && st_d != WATER;
    end
  end
  assign valve_j  = j_q;
  assign valve_k  = k_q;
  assign valve_on = st_q == WATER;
  assign state    = st_q;
  assign alarm    = st_q == FAULT;
endmodule
